// File: rtl/quarter_table_encoder.sv
// Run-length encoder that packs 7-bit quarter-wave amplitudes into {amp, hold}
// table words and writes them sequentially into the DDS table memory.
module quarter_table_encoder #(
    parameter int DATA_LEN      = 11,
    parameter int ROWS_BASE_2   = 8,
    parameter int MEMORY_HEIGHT = 256
) (
    input  logic                   src_clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sample_valid,
    input  logic [6:0]             sample,
    input  logic                   sample_last,
    output logic                   sample_ready,
    output logic [DATA_LEN-1:0]    data_wr,
    output logic [ROWS_BASE_2-1:0] addr_wr,
    output logic                   we,
    output logic [ROWS_BASE_2:0]   word_count,
    output logic                   done,
    output logic                   overflow
);

    typedef enum logic [2:0] {
        S_IDLE, S_FIRST, S_RUN, S_FLUSH, S_DONE, S_FULL
    } state_t;

    localparam logic [ROWS_BASE_2:0] HEIGHT = (ROWS_BASE_2+1)'(MEMORY_HEIGHT);

    state_t                  state_reg, state_next;
    logic [6:0]              cur_amp_reg, cur_amp_next;
    logic [3:0]              run_cnt_reg, run_cnt_next;
    logic [ROWS_BASE_2:0]    word_count_reg, word_count_next;
    logic [DATA_LEN-1:0]     data_reg, data_next;
    logic [ROWS_BASE_2-1:0]  addr_reg, addr_next;
    logic                    we_reg, we_next;
    logic                    ready_reg, done_reg, overflow_reg;
    logic                    accept;
    logic                    emit;

    assign accept = sample_valid && ready_reg;

    always_comb begin
        state_next      = state_reg;
        cur_amp_next    = cur_amp_reg;
        run_cnt_next    = run_cnt_reg;
        word_count_next = word_count_reg;
        data_next       = data_reg;
        addr_next       = addr_reg;
        we_next         = 1'b0;
        emit            = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE, S_FULL: begin
                if (start) begin
                    word_count_next = '0;
                    state_next      = S_FIRST;
                end
            end
            S_FIRST: begin
                if (accept) begin
                    cur_amp_next = sample;
                    run_cnt_next = 4'd0;
                    state_next   = sample_last ? S_FLUSH : S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (sample == cur_amp_reg && run_cnt_reg != 4'd15) begin
                        run_cnt_next = run_cnt_reg + 4'd1;
                    end else begin
                        emit         = 1'b1;
                        cur_amp_next = sample;
                        run_cnt_next = 4'd0;
                    end
                    if (sample_last) state_next = S_FLUSH;
                end
            end
            S_FLUSH: begin
                emit       = 1'b1;
                state_next = S_DONE;
            end
            default: state_next = S_IDLE;
        endcase

        // The emitted word always describes the run as it stood before this edge.
        if (emit) begin
            if (word_count_reg < HEIGHT) begin
                data_next       = '0;
                data_next[10:4] = cur_amp_reg;
                data_next[3:0]  = run_cnt_reg;
                addr_next       = word_count_reg[ROWS_BASE_2-1:0];
                we_next         = 1'b1;
                word_count_next = word_count_reg + (ROWS_BASE_2+1)'(1);
            end else begin
                state_next = S_FULL;
            end
        end
    end

    always_ff @(posedge src_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            cur_amp_reg    <= '0;
            run_cnt_reg    <= '0;
            word_count_reg <= '0;
            data_reg       <= '0;
            addr_reg       <= '0;
            we_reg         <= 1'b0;
            ready_reg      <= 1'b0;
            done_reg       <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cur_amp_reg    <= cur_amp_next;
            run_cnt_reg    <= run_cnt_next;
            word_count_reg <= word_count_next;
            data_reg       <= data_next;
            addr_reg       <= addr_next;
            we_reg         <= we_next;
            // Status flags are registered copies of the next-state decode.
            ready_reg      <= (state_next == S_FIRST) || (state_next == S_RUN);
            done_reg       <= (state_next == S_DONE);
            overflow_reg   <= (state_next == S_FULL);
        end
    end

    assign sample_ready = ready_reg;
    assign data_wr      = data_reg;
    assign addr_wr      = addr_reg;
    assign we           = we_reg;
    assign word_count   = word_count_reg;
    assign done         = done_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_quarter_table_encoder.sv
// Directed bench for quarter_table_encoder: drives sample streams and checks
// the captured table writes and status levels against hand-computed values.
module tb_quarter_table_encoder;

    logic        src_clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        sample_valid;
    logic [6:0]  sample;
    logic        sample_last;
    logic        sample_ready;
    logic [10:0] data_wr;
    logic [7:0]  addr_wr;
    logic        we;
    logic [8:0]  word_count;
    logic        done;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  wr_addr_q[$];
    logic [10:0] wr_data_q[$];
    logic        wr_done_q[$];

    quarter_table_encoder dut (
        .src_clk      (src_clk),
        .rst_n        (rst_n),
        .start        (start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .sample_last  (sample_last),
        .sample_ready (sample_ready),
        .data_wr      (data_wr),
        .addr_wr      (addr_wr),
        .we           (we),
        .word_count   (word_count),
        .done         (done),
        .overflow     (overflow)
    );

    always #5 src_clk = ~src_clk;

    always @(negedge src_clk) begin
        if (we) begin
            wr_addr_q.push_back(addr_wr);
            wr_data_q.push_back(data_wr);
            wr_done_q.push_back(done);
            $display("WR addr=%0d data=0x%03h done=%0b", addr_wr, data_wr, done);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_done_q.delete();
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [6:0] s, input logic l);
        int t = 0;
        sample_valid = 1'b1;
        sample       = s;
        sample_last  = l;
        while (!sample_ready && t < 50) begin
            @(negedge src_clk);
            t++;
        end
        if (!sample_ready) check("send_ready", {31'd0, sample_ready}, 32'd1);
        @(negedge src_clk);
        sample_valid = 1'b0;
        sample_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge src_clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int t = 0;
        while (!(done || overflow) && t < 40) begin
            @(negedge src_clk);
            t++;
        end
        check(tag, {31'd0, done | overflow}, 32'd1);
    endtask

    task automatic settle();
        repeat (2) @(negedge src_clk);
        #1;
    endtask

    // Sequence 10,10,10,20 with optional random gaps and a start pulse mid-RUN.
    task automatic run_seq1(input bit gapped, input string pfx);
        logic [6:0] seq [4];
        seq[0] = 7'd10; seq[1] = 7'd10; seq[2] = 7'd10; seq[3] = 7'd20;
        for (int i = 0; i < 4; i++) begin
            if (gapped) repeat ($urandom_range(0, 3)) @(negedge src_clk);
            if (gapped && i == 2) begin
                pulse_start();
                check({pfx, "_ready_after_start"}, {31'd0, sample_ready}, 32'd1);
            end
            send(seq[i], i == 3);
        end
        wait_end({pfx, "_end"});
        check({pfx, "_done"}, {31'd0, done}, 32'd1);
        check({pfx, "_wc"}, {23'd0, word_count}, 32'd2);
        settle();
        check({pfx, "_nwr"}, wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check({pfx, "_a0"}, {24'd0, wr_addr_q[0]}, 32'd0);
            check({pfx, "_d0"}, {21'd0, wr_data_q[0]}, 32'h0A2);
            check({pfx, "_done_w0"}, {31'd0, wr_done_q[0]}, 32'd0);
            check({pfx, "_a1"}, {24'd0, wr_addr_q[1]}, 32'd1);
            check({pfx, "_d1"}, {21'd0, wr_data_q[1]}, 32'h140);
            check({pfx, "_done_w1"}, {31'd0, wr_done_q[1]}, 32'd1);
        end
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; start = 1'b0; sample_valid = 1'b0; sample = '0; sample_last = 1'b0;
        repeat (3) @(negedge src_clk);
        check("rst_ready", {31'd0, sample_ready}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_data", {21'd0, data_wr}, 32'd0);
        check("rst_addr", {24'd0, addr_wr}, 32'd0);
        check("rst_wc", {23'd0, word_count}, 32'd0);
        rst_n = 1'b1;
        @(negedge src_clk);
        check("idle_ready", {31'd0, sample_ready}, 32'd0);

        // Basic run-length load.
        clear_log();
        pulse_start();
        check("first_ready", {31'd0, sample_ready}, 32'd1);
        run_seq1(1'b0, "t1");

        // Seventeen repeats: the 17th breaks the saturated run.
        clear_log();
        pulse_start();
        check("t2_done_cleared", {31'd0, done}, 32'd0);
        check("t2_wc_cleared", {23'd0, word_count}, 32'd0);
        for (int i = 0; i < 16; i++) send(7'd5, 1'b0);
        #1;
        check("t2_no_early_wr", wr_addr_q.size(), 32'd0);
        send(7'd5, 1'b1);
        wait_end("t2_end");
        settle();
        check("t2_nwr", wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check("t2_a0", {24'd0, wr_addr_q[0]}, 32'd0);
            check("t2_d0", {21'd0, wr_data_q[0]}, 32'h05F);
            check("t2_a1", {24'd0, wr_addr_q[1]}, 32'd1);
            check("t2_d1", {21'd0, wr_data_q[1]}, 32'h050);
        end

        // Single sample carrying last.
        clear_log();
        pulse_start();
        send(7'd127, 1'b1);
        check("t3_done_early", {31'd0, done}, 32'd0);
        check("t3_we_early", {31'd0, we}, 32'd0);
        @(negedge src_clk);
        check("t3_done", {31'd0, done}, 32'd1);
        check("t3_we", {31'd0, we}, 32'd1);
        check("t3_data", {21'd0, data_wr}, 32'h7F0);
        check("t3_addr", {24'd0, addr_wr}, 32'd0);
        settle();
        check("t3_nwr", wr_addr_q.size(), 32'd1);

        // Overflow: 257 alternating samples give 257 words for a 256-word table.
        clear_log();
        pulse_start();
        for (int i = 0; i < 257; i++) send(7'(i % 2), i == 256);
        wait_end("t4_end");
        check("t4_ovf", {31'd0, overflow}, 32'd1);
        check("t4_done", {31'd0, done}, 32'd0);
        check("t4_ready", {31'd0, sample_ready}, 32'd0);
        check("t4_wc", {23'd0, word_count}, 32'd256);
        repeat (4) @(negedge src_clk);
        #1;
        check("t4_nwr", wr_addr_q.size(), 32'd256);
        bad = 0;
        for (int k = 0; k < wr_addr_q.size(); k++) begin
            if (wr_addr_q[k] != 8'(k) || wr_data_q[k] != 11'((k % 2) << 4)) bad++;
        end
        check("t4_words", bad, 32'd0);
        pulse_start();
        check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
        check("t4_ready_after", {31'd0, sample_ready}, 32'd1);
        check("t4_wc_cleared", {23'd0, word_count}, 32'd0);

        // Gapped valid plus an ignored mid-RUN start (already in FIRST).
        clear_log();
        run_seq1(1'b1, "t5");

        // Asynchronous reset mid-RUN after two writes.
        clear_log();
        pulse_start();
        send(7'd1, 1'b0);
        send(7'd2, 1'b0);
        send(7'd3, 1'b0);
        check("t6_we_before", {31'd0, we}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_we", {31'd0, we}, 32'd0);
        check("t6_rst_wc", {23'd0, word_count}, 32'd0);
        check("t6_rst_done", {31'd0, done}, 32'd0);
        check("t6_rst_ovf", {31'd0, overflow}, 32'd0);
        check("t6_rst_ready", {31'd0, sample_ready}, 32'd0);
        @(negedge src_clk);
        rst_n = 1'b1;
        @(negedge src_clk);
        #1;
        check("t6_nwr_before", wr_addr_q.size(), 32'd2);
        clear_log();
        pulse_start();
        send(7'd9, 1'b1);
        wait_end("t6_end");
        settle();
        check("t6_nwr", wr_addr_q.size(), 32'd1);
        if (wr_addr_q.size() == 1) begin
            check("t6_a0", {24'd0, wr_addr_q[0]}, 32'd0);
            check("t6_d0", {21'd0, wr_data_q[0]}, 32'h090);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/quarter_table_encoder.md
# quarter_table_encoder

Run-length encoder that turns a stream of 7-bit quarter-wave amplitude samples into the packed table words the DDS reads: amplitude in bits [10:4], hold count in bits [3:0]. It drives the DDS memory write port (data_wr, addr_wr, we) and loads the quarter-sine table from address 0 upward. A hold count of N means the DDS keeps that amplitude for N+1 wave ticks, so a run of length L is stored as count L-1, with at most 16 samples per word.

## Interface
- DATA_LEN, 11, table word width; bits above [10] written as 0
- ROWS_BASE_2, 8, address width
- MEMORY_HEIGHT, 256, number of table words; legal addresses are 0..MEMORY_HEIGHT-1
- src_clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new table load; honoured only in IDLE, DONE or FULL
- sample_valid  in  1  sample offered
- sample  in  7  amplitude, 0..127
- sample_last  in  1  marks the final sample of the table; qualified by sample_valid
- sample_ready  out  1  encoder accepts the sample this cycle
- data_wr  out  DATA_LEN  table word, {zeros, amp[6:0], cnt[3:0]}
- addr_wr  out  ROWS_BASE_2  table address
- we  out  1  one-cycle write strobe
- word_count  out  ROWS_BASE_2+1  number of words written since start
- done  out  1  table fully written; level
- overflow  out  1  table exceeded MEMORY_HEIGHT; level

## Operation
- Reset values: state IDLE; sample_ready, we, done and overflow are 0; data_wr, addr_wr and word_count are 0; the run registers (cur_amp, run_cnt) are 0.
- A sample is accepted when sample_valid and sample_ready are both high at a clock edge. sample_ready is 1 only in the FIRST and RUN states.
- States:
  - IDLE: on start, clear word_count and go to FIRST.
  - FIRST: no run is open. Accepting a sample sets cur_amp=sample and run_cnt=0. Go to FLUSH if sample_last, else to RUN.
  - RUN: on an accepted sample:
    - If sample==cur_amp and run_cnt<15: increment run_cnt.
    - Otherwise: emit {cur_amp, run_cnt}, then open a new run with cur_amp=sample and run_cnt=0.
    - If sample_last, go to FLUSH in either case.
  - FLUSH: emit {cur_amp, run_cnt} and go to DONE.
  - DONE: done=1. A start pulse clears done and word_count and goes to FIRST.
  - FULL: overflow=1 and no further writes. A start pulse clears the error and goes to FIRST.
- Emit operation:
  - If word_count < MEMORY_HEIGHT: register data_wr, set addr_wr=word_count[ROWS_BASE_2-1:0], pulse we for one cycle, then increment word_count.
  - Otherwise: suppress the write and go to FULL. This overrides any transition to FLUSH or DONE.
- start is ignored in FIRST, RUN and FLUSH.
- sample_valid is ignored while sample_ready is 0; no sample is lost or duplicated when valid has gaps.
- Reset mid-load abandons the load immediately. Words already written stay in memory and are not rolled back.

## Timing
- All outputs are registered.
- we, data_wr and addr_wr appear in the cycle after the edge that accepted the run-breaking sample, or the cycle after the FLUSH edge.
- Between strobes, data_wr and addr_wr hold their last values.
- The final we pulse and done=1 appear in the same cycle.
- At most one write per cycle. If the last sample breaks a run, the closing word is written one cycle after acceptance and the final word one cycle later.
- Write throughput is at most one word per accepted sample.
- The DDS muxes its address on we, so table loading is done with the DDS idle.

## Test plan
- Samples 10, 10, 10, 20 (last) -> we at addr 0 with data 0x0A2, then addr 1 with 0x140; word_count=2; done=1 in the same cycle as the second we.
- 17 samples of 5, last on the 17th -> addr 0 = 0x05F, addr 1 = 0x050; no write before the 16th repeat breaks the run.
- Single sample 127 with last, directly after start -> exactly one write, addr 0 = 0x7F0; done=1 two cycles after acceptance.
- 257 alternating samples 0, 1, ..., last on the 257th -> 256 writes at addresses 0..255; overflow=1, done=0, sample_ready=0, no 257th we; start then clears overflow and returns to FIRST.
- Sequence from the first test with sample_valid randomly gapped, plus a start pulse mid-RUN -> writes identical to the ungapped run; the mid-RUN start is ignored.
- rst_n asserted asynchronously mid-RUN after 2 writes -> we, done and overflow drop immediately and word_count=0; a fresh start and load then writes from addr 0.
